// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one instruction in flight, issues aligned
// dcache requests with byte enables and formats returned load data.
module mem_access_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [1:0]        op_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic              dc_req_we,
  output logic [XLEN-1:0]   dc_req_addr,
  output logic [XLEN-1:0]   dc_req_wdata,
  output logic [XLEN/8-1:0] dc_req_be,
  input  logic              dc_resp_valid,
  input  logic [XLEN-1:0]   dc_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [XLEN-1:0]   result_o,
  output logic              misalign_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  // state | meaning: IDLE accept input | REQ dcache request | WAIT load data | DONE result out
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;

  logic [OW-1:0]   off_q;
  logic [1:0]      size_q;
  logic            unsigned_q;

  logic [OW-1:0]   off_in;
  int              off_int;
  int              nbytes;
  logic            is_mem;
  logic            misalign;
  logic [NB-1:0]   be_in;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] aligned_addr;

  int              nb_q;
  logic [XLEN-1:0] shifted;
  logic            sign;
  logic [XLEN-1:0] load_val;

  assign in_ready     = (state == IDLE);
  assign dc_req_valid = (state == REQ);
  assign out_valid    = (state == DONE);

  always_comb begin
    off_in       = addr_i[OW-1:0];
    off_int      = int'(off_in);
    nbytes       = 1 << size_i;
    is_mem       = (op_i == 2'b01) || (op_i == 2'b10);
    // dword is illegal on a 32-bit datapath and is reported as a misalignment
    misalign     = ((XLEN == 32) && (size_i == 2'b11)) || ((off_int & (nbytes - 1)) != 0);
    aligned_addr = addr_i & ~XLEN'(NB - 1);
    be_in        = '0;
    for (int i = 0; i < NB; i++)
      be_in[i] = (i >= off_int) && (i < off_int + nbytes);
    case (size_i)
      2'b00:   wdata_rep = {NB{wdata_i[7:0]}};
      2'b01:   wdata_rep = {(NB/2){wdata_i[15:0]}};
      2'b10:   wdata_rep = {(NB/4){wdata_i[31:0]}};
      default: wdata_rep = wdata_i;
    endcase
  end

  always_comb begin
    nb_q    = 1 << size_q;
    shifted = dc_resp_data >> {off_q, 3'b000};
    case (size_q)
      2'b00:   sign = shifted[7];
      2'b01:   sign = shifted[15];
      2'b10:   sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    load_val = '0;
    for (int b = 0; b < XLEN; b++)
      load_val[b] = (b < 8 * nb_q) ? shifted[b] : (sign & ~unsigned_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      pc_o         <= '0;
      rd_o         <= '0;
      result_o     <= '0;
      misalign_o   <= 1'b0;
      dc_req_we    <= 1'b0;
      dc_req_be    <= '0;
      dc_req_addr  <= '0;
      dc_req_wdata <= '0;
      off_q        <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          pc_o         <= pc_i;
          rd_o         <= rd_i;
          off_q        <= off_in;
          size_q       <= size_i;
          unsigned_q   <= unsigned_i;
          dc_req_addr  <= aligned_addr;
          dc_req_wdata <= wdata_rep;
          misalign_o   <= is_mem && misalign;
          if (!is_mem || misalign) begin
            result_o  <= addr_i;
            dc_req_we <= 1'b0;
            dc_req_be <= '0;
            state     <= DONE;
          end else begin
            result_o  <= '0;
            dc_req_we <= (op_i == 2'b10);
            dc_req_be <= be_in;
            state     <= REQ;
          end
        end
        REQ: if (dc_req_ready) state <= dc_req_we ? DONE : WAIT;
        WAIT: if (dc_resp_valid) begin
          result_o <= load_val;
          state    <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage against a byte-level
// reference model; a stray dcache response is injected whenever it must be ignored.
module tb_mem_access_stage;
  localparam int XLEN = 32;
  localparam int PC_W = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [PC_W-1:0] pc_i = '0;
  logic [RD_W-1:0] rd_i = '0;
  logic [1:0]      op_i = '0;
  logic [1:0]      size_i = '0;
  logic            unsigned_i = 1'b0;
  logic [XLEN-1:0] addr_i = '0;
  logic [XLEN-1:0] wdata_i = '0;
  logic            dc_req_valid;
  logic            dc_req_ready = 1'b0;
  logic            dc_req_we;
  logic [XLEN-1:0] dc_req_addr;
  logic [XLEN-1:0] dc_req_wdata;
  logic [XLEN/8-1:0] dc_req_be;
  logic            dc_resp_valid = 1'b0;
  logic [XLEN-1:0] dc_resp_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PC_W-1:0] pc_o;
  logic [RD_W-1:0] rd_o;
  logic [XLEN-1:0] result_o;
  logic            misalign_o;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(XLEN), .PC_W(PC_W), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .rd_i(rd_i), .op_i(op_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o), .rd_o(rd_o),
    .result_o(result_o), .misalign_o(misalign_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: works on byte counts and plain arithmetic over a 32-bit word.
  function automatic void model(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] resp,
                                output logic req, output logic mis, output logic [31:0] raddr,
                                output logic [31:0] rwdata, output logic [3:0] be, output logic [31:0] res);
    longint unsigned nb, off, m, v, lanes;
    logic is_mem;
    nb     = longint'(1) << size;
    off    = longint'(addr) % 4;
    is_mem = (op == 2'd1) || (op == 2'd2);
    mis    = is_mem && (size == 2'd3 || (longint'(addr) % nb) != 0);
    req    = is_mem && !mis;
    raddr  = 32'(longint'(addr) - off);
    lanes  = ((longint'(1) << nb) - 1) << off;
    be     = 4'(lanes);
    m      = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (longint'(1) << (8 * nb)) - 1;
    v      = longint'(wdata) & m;
    rwdata = '0;
    for (longint unsigned k = 0; k < 4; k += nb) rwdata |= 32'(v << (8 * k));
    if (!is_mem || mis) res = addr;
    else if (op == 2'd2) res = '0;
    else begin
      v = (longint'(resp) >> (8 * off)) & m;
      if (!uns && v > m / 2) v = v | ~m;
      res = 32'(v);
    end
  endfunction

  task automatic run_txn(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] resp,
                         input logic [31:0] pc, input logic [4:0] rd,
                         input int req_stall, input int resp_delay, input int out_stall);
    logic req, mis;
    logic [31:0] raddr, rwd, res;
    logic [3:0] be;
    model(op, size, uns, addr, wdata, resp, req, mis, raddr, rwd, be, res);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; pc_i = pc; rd_i = rd; op_i = op; size_i = size;
    unsigned_i = uns; addr_i = addr; wdata_i = wdata;
    step();
    // keep offering a different instruction while busy; it must not be taken
    pc_i = ~pc; addr_i = $urandom; wdata_i = $urandom; op_i = 2'($urandom);
    if (req) begin
      for (int s = 0; s <= req_stall; s++) begin
        check("req_valid", dc_req_valid, 1);
        check("req_addr", dc_req_addr, raddr);
        check("req_be", dc_req_be, be);
        check("req_we", dc_req_we, (op == 2'd2));
        if (op == 2'd2) check("req_wdata", dc_req_wdata, rwd);
        check("busy_in_ready", in_ready, 0);
        check("req_no_out", out_valid, 0);
        if (s == req_stall) dc_req_ready = 1;
        else begin dc_resp_valid = 1; dc_resp_data = $urandom; end
        step();
        dc_req_ready = 0; dc_resp_valid = 0;
      end
      if (op == 2'd1) begin
        for (int s = 0; s <= resp_delay; s++) begin
          check("wait_no_req", dc_req_valid, 0);
          check("wait_no_out", out_valid, 0);
          if (s == resp_delay) begin dc_resp_valid = 1; dc_resp_data = resp; end
          step();
          dc_resp_valid = 0;
        end
      end
    end
    for (int s = 0; s <= out_stall; s++) begin
      check("out_valid", out_valid, 1);
      check("out_no_req", dc_req_valid, 0);
      check("pc_o", pc_o, pc);
      check("rd_o", rd_o, rd);
      check("result_o", result_o, res);
      check("misalign_o", misalign_o, mis);
      check("done_in_ready", in_ready, 0);
      if (s == out_stall) begin out_ready = 1; in_valid = 0; end
      else begin dc_resp_valid = 1; dc_resp_data = $urandom; end
      step();
      out_ready = 0; dc_resp_valid = 0;
    end
    check("after_done", out_valid, 0);
    check("back_idle", in_ready, 1);
  endtask

  initial begin
    logic [1:0] op, size;
    logic [31:0] a;
    // reset state
    reset = 0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", dc_req_valid, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_result", result_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_we", dc_req_we, 0);
    check("rst_be", dc_req_be, 0);
    reset = 1;
    step();

    run_txn(2'd0, 2'd2, 0, 32'h1234, 32'h0, 32'h0, 32'h100, 5'd3, 0, 0, 0);
    run_txn(2'd2, 2'd0, 0, 32'h1003, 32'hAB, 32'h0, 32'h104, 5'd0, 0, 0, 0);
    run_txn(2'd1, 2'd1, 0, 32'h2002, 32'h0, 32'h8001_0000, 32'h108, 5'd7, 0, 0, 0);
    run_txn(2'd1, 2'd1, 1, 32'h2002, 32'h0, 32'h8001_0000, 32'h10C, 5'd8, 0, 0, 0);
    run_txn(2'd1, 2'd2, 0, 32'h2001, 32'h0, 32'h0, 32'h110, 5'd9, 0, 0, 0);
    run_txn(2'd2, 2'd1, 0, 32'h3006, 32'h1234_BEEF, 32'h0, 32'h114, 5'd1, 3, 0, 2);
    run_txn(2'd1, 2'd3, 0, 32'h4000, 32'h0, 32'h0, 32'h118, 5'd2, 0, 0, 0);
    run_txn(2'd3, 2'd0, 0, 32'h5001, 32'h0, 32'h0, 32'h11C, 5'd4, 0, 0, 1);
    run_txn(2'd1, 2'd0, 0, 32'h6001, 32'h0, 32'h0000_F600, 32'h120, 5'd5, 1, 2, 0);

    // reset while a load waits for its response; the late response must vanish
    in_valid = 1; op_i = 2'd1; size_i = 2'd2; addr_i = 32'h7000; pc_i = 32'h200; rd_i = 5'd6;
    step();
    in_valid = 0; dc_req_ready = 1;
    step();
    dc_req_ready = 0;
    check("wait_state_no_req", dc_req_valid, 0);
    reset = 0;
    step();
    reset = 1;
    check("wrst_out_valid", out_valid, 0);
    check("wrst_req_valid", dc_req_valid, 0);
    check("wrst_pc", pc_o, 0);
    check("wrst_result", result_o, 0);
    check("wrst_in_ready", in_ready, 1);
    dc_resp_valid = 1; dc_resp_data = 32'hDEAD_BEEF;
    step();
    dc_resp_valid = 0;
    check("late_resp_out", out_valid, 0);
    check("late_resp_idle", in_ready, 1);
    step();
    check("late_resp_out2", out_valid, 0);
    run_txn(2'd1, 2'd2, 0, 32'h7004, 32'h0, 32'h8765_4321, 32'h204, 5'd10, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      size = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << size) - 32'd1);
      run_txn(op, size, 1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter PC_W, default 32, program-counter width.
REQ-003 Parameter RD_W, default 5, destination-register index width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low; sampled on the clk rising edge.
REQ-006 in_valid  input  1 / in_ready  output  1  upstream handshake.
REQ-007 pc_i  input  PC_W; rd_i  input  RD_W; op_i  input  2 (00 pass, 01 load, 10 store, 11 reserved, treated as pass); size_i  input  2 (00 byte, 01 half, 10 word, 11 dword); unsigned_i  input  1; addr_i  input  XLEN (ALU result or address); wdata_i  input  XLEN.
REQ-008 dc_req_valid  output  1; dc_req_ready  input  1; dc_req_we  output  1; dc_req_addr  output  XLEN; dc_req_wdata  output  XLEN; dc_req_be  output  XLEN/8.
REQ-009 dc_resp_valid  input  1; dc_resp_data  input  XLEN.
REQ-010 out_valid  output  1; out_ready  input  1; pc_o  output  PC_W; rd_o  output  RD_W; result_o  output  XLEN; misalign_o  output  1.

Function
REQ-011 FSM states: IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-012 IDLE, in_valid=1: capture all inputs; pass op -> DONE; misaligned or illegal access -> DONE; load/store -> REQ.
REQ-013 Access misaligned when addr_i is not a multiple of the access size; size 11 with XLEN=32 is illegal; either case sets misalign_o=1 and issues no dcache request.
REQ-014 REQ: dc_req_valid=1, with addr/we/wdata/be held stable until dc_req_ready=1; on handshake, store -> DONE, load -> WAIT.
REQ-015 dc_req_addr SHALL equal the captured address with its low log2(XLEN/8) bits cleared.
REQ-016 dc_req_be: size mask (1, 3, 0xF, 0xFF) shifted left by the address byte offset; dc_req_wdata: low size bytes of wdata_i replicated across all lanes.
REQ-017 WAIT: on dc_resp_valid=1, shift data right by offset*8, keep size bytes, sign-extend (unsigned_i=0) or zero-extend (unsigned_i=1) into result_o, then -> DONE.
REQ-018 dc_resp_valid outside WAIT SHALL be ignored.
REQ-019 DONE: out_valid=1, with pc_o/rd_o/result_o/misalign_o held stable; on out_ready=1 -> IDLE.
REQ-020 result_o: pass -> captured addr_i; store -> 0; misaligned -> captured addr_i.
REQ-021 Latency with ready/resp in the earliest cycle: pass 1 cycle (out_valid in the cycle after acceptance); store 2 cycles; load 3 cycles.
REQ-022 Backpressure: the stage holds in REQ or DONE indefinitely, with no output change, while ready is low.
REQ-023 The stage accepts no new input until the DONE handshake completes; one instruction in flight.

Reset
REQ-024 reset=0 at a clk edge SHALL force IDLE from any state, with out_valid=0, dc_req_valid=0, misalign_o=0, result_o=0, pc_o=0, rd_o=0, dc_req_we=0, dc_req_be=0.
REQ-025 A response to a request outstanding at reset SHALL be discarded (REQ-018).

Verification
REQ-026 Pass op, pc_i=0x100, addr_i=0x1234, out_ready=1 -> out_valid 1 cycle later, pc_o=0x100, result_o=0x1234, no dc_req_valid.
REQ-027 Store byte at addr 0x1003, wdata 0xAB -> dc_req_addr=0x1000, be=0x8, wdata=0xABABABAB, out_valid 2 cycles after acceptance.
REQ-028 Signed half load at 0x2002, resp 0x8001_0000 -> result_o=0xFFFF8001; the same access unsigned -> 0x00008001.
REQ-029 Word load at 0x2001 -> misalign_o=1, result_o=0x2001, no dcache request.
REQ-030 dc_req_ready low 3 cycles, then out_ready low 2 cycles -> request and output fields stable throughout, in_ready=0 until the DONE handshake.
REQ-031 reset=0 while in WAIT, then late dc_resp_valid -> IDLE, out_valid stays 0, next instruction processed normally.
